// File: rtl/manchester_pkg.sv
// Shared types and constants for the Manchester line codec.
// Timer widths are sized from the full frame length so one width serves both TX and RX.
package manchester_pkg;

   localparam int FRAME_BITS = 9;
   localparam int DATA_BITS  = 8;

   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_BIT, RX_WAIT_IDLE} rx_state_e;

   function automatic int frame_cycles(input int half, input int idle);
      return (FRAME_BITS + idle) * 2 * half;
   endfunction

   function automatic int timer_w(input int half, input int idle);
      return $clog2(frame_cycles(half, idle) + 1);
   endfunction

endpackage

// File: rtl/manchester_rx.sv
// Manchester receiver: input synchronizer, edge detection, mid-bit tracking FSM.
// The timer restarts on every accepted mid-bit edge, so drift never accumulates.
module manchester_rx
   import manchester_pkg::*;
#(
   parameter int HALF_BIT_CYCLES = 4,
   parameter int IDLE_BITS       = 2
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 serial_in,
   input  logic                 sample_en,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err
);

   localparam int TW = timer_w(HALF_BIT_CYCLES, IDLE_BITS);
   localparam logic [TW-1:0] T_SAMPLE  = TW'(3 * HALF_BIT_CYCLES / 2 - 1);
   localparam logic [TW-1:0] T_TIMEOUT = TW'(5 * HALF_BIT_CYCLES / 2);
   localparam logic [TW-1:0] T_QUIET   = TW'(2 * HALF_BIT_CYCLES - 1);

   rx_state_e state_q, state_d;
   logic sync1_q, sync2_q, prev_q;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [2:0] cnt_q, cnt_d;
   logic bit_q, bit_d, sampled_q, sampled_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
   logic dv_q, dv_d, fe_q, fe_d;
   logic rise, fall;

   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      sampled_d = sampled_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      dv_d      = 1'b0;
      fe_d      = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (rise) begin
               state_d   = RX_BIT;
               tmr_d     = '0;
               cnt_d     = '0;
               sampled_d = 1'b0;
            end
         end
         RX_BIT: begin
            if (sample_en) tmr_d = tmr_q + TW'(1);
            // Edges before the sample point are bit-boundary transitions and are ignored.
            if (!sampled_q) begin
               if (sample_en && tmr_q == T_SAMPLE) begin
                  sampled_d = 1'b1;
                  bit_d     = ~sync2_q;
               end
            end else if (rise || fall) begin
               if (rise == bit_q) begin
                  shreg_d   = {shreg_q[DATA_BITS-2:0], bit_q};
                  cnt_d     = cnt_q + 3'd1;
                  tmr_d     = '0;
                  sampled_d = 1'b0;
                  if (cnt_q == 3'd7) begin
                     data_d  = {shreg_q[DATA_BITS-2:0], bit_q};
                     dv_d    = 1'b1;
                     state_d = RX_WAIT_IDLE;
                  end
               end else begin
                  fe_d    = 1'b1;
                  tmr_d   = '0;
                  state_d = RX_WAIT_IDLE;
               end
            end else if (sample_en && tmr_q >= T_TIMEOUT) begin
               fe_d    = 1'b1;
               tmr_d   = '0;
               state_d = RX_WAIT_IDLE;
            end
         end
         RX_WAIT_IDLE: begin
            if (sample_en) begin
               if (sync2_q)                tmr_d = '0;
               else if (tmr_q == T_QUIET)  state_d = RX_IDLE;
               else                        tmr_d = tmr_q + TW'(1);
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= RX_IDLE;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= serial_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         data_q  <= data_d;
         dv_q    <= dv_d;
         fe_q    <= fe_d;
      end
   end

   always_ff @(posedge aclk) begin
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sampled_q <= sampled_d;
      shreg_q   <= shreg_d;
   end

   assign data_out   = data_q;
   assign data_valid = dv_q;
   assign frame_err  = fe_q;

endmodule

// File: rtl/manchester_codec.sv
// Manchester codec top: inline byte transmitter plus the manchester_rx receiver.
// TX sends a start bit and eight data bits MSB-first, then holds the line low for the idle gap.
module manchester_codec
   import manchester_pkg::*;
#(
   parameter int HALF_BIT_CYCLES = 4,
   parameter int IDLE_BITS       = 2
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic [DATA_BITS-1:0] s_axis_tdata,
   output logic                 serial_out,
   input  logic                 serial_in,
   input  logic                 sample_en,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err
);

   localparam int TW  = timer_w(HALF_BIT_CYCLES, IDLE_BITS);
   localparam int HBW = $clog2(2 * FRAME_BITS + 1);
   localparam logic [TW-1:0]  HALF_LAST = TW'(HALF_BIT_CYCLES - 1);
   localparam logic [TW-1:0]  GAP_LAST  = TW'(IDLE_BITS * 2 * HALF_BIT_CYCLES - 1);
   localparam logic [HBW-1:0] HB_LAST   = HBW'(2 * FRAME_BITS - 1);

   tx_state_e state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [HBW-1:0] hb_q, hb_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic tready_q, tready_d, serial_q, serial_d;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      hb_d    = hb_q;
      shreg_d = shreg_q;
      case (state_q)
         TX_IDLE: begin
            if (s_axis_tvalid && tready_q) begin
               state_d = TX_SEND;
               tmr_d   = '0;
               hb_d    = '0;
               shreg_d = {1'b1, s_axis_tdata};
            end
         end
         TX_SEND: begin
            if (tmr_q == HALF_LAST) begin
               tmr_d = '0;
               hb_d  = hb_q + HBW'(1);
               if (hb_q[0])         shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
               if (hb_q == HB_LAST) state_d = TX_GAP;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         TX_GAP: begin
            if (tmr_q == GAP_LAST) state_d = TX_IDLE;
            else                   tmr_d   = tmr_q + TW'(1);
         end
         default: state_d = TX_IDLE;
      endcase
      // Output is registered from next-state values so the line never glitches.
      tready_d = (state_d == TX_IDLE);
      serial_d = (state_d == TX_SEND) &&
                 (hb_d[0] ? shreg_d[FRAME_BITS-1] : ~shreg_d[FRAME_BITS-1]);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q  <= TX_IDLE;
         tready_q <= 1'b0;
         serial_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tready_q <= tready_d;
         serial_q <= serial_d;
      end
   end

   always_ff @(posedge aclk) begin
      tmr_q   <= tmr_d;
      hb_q    <= hb_d;
      shreg_q <= shreg_d;
   end

   assign s_axis_tready = tready_q;
   assign serial_out    = serial_q;

   manchester_rx #(
      .HALF_BIT_CYCLES(HALF_BIT_CYCLES),
      .IDLE_BITS      (IDLE_BITS)
   ) u_rx (
      .aclk      (aclk),
      .areset    (areset),
      .serial_in (serial_in),
      .sample_en (sample_en),
      .data_out  (data_out),
      .data_valid(data_valid),
      .frame_err (frame_err)
   );

endmodule

// File: tb/tb_manchester_codec.sv
// Bench for manchester_codec: waveform model, loopback decode, handshake, error and reset scenarios.
module tb_manchester_codec;

   localparam int H         = 4;
   localparam int IDLE      = 2;
   localparam int FRAME_LEN = (9 + IDLE) * 2 * H;

   typedef logic wave_t[$];

   logic       aclk = 1'b0;
   logic       areset = 1'b1;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic [7:0] s_axis_tdata = 8'h00;
   logic       serial_out;
   logic       serial_in;
   logic       sample_en = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;

   logic       loop_en = 1'b1;
   logic       ext_line = 1'b0;
   logic       slow_se = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         fe_cnt = 0;
   logic [7:0] rx_q[$];

   always #5 aclk = ~aclk;
   assign serial_in = loop_en ? serial_out : ext_line;

   manchester_codec #(.HALF_BIT_CYCLES(H), .IDLE_BITS(IDLE)) dut (
      .aclk         (aclk),
      .areset       (areset),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tdata (s_axis_tdata),
      .serial_out   (serial_out),
      .serial_in    (serial_in),
      .sample_en    (sample_en),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .frame_err    (frame_err)
   );

   // Receive-side monitor: collects decoded bytes and error strobes.
   initial forever begin
      @(negedge aclk);
      if (data_valid === 1'b1) rx_q.push_back(data_out);
      if (frame_err === 1'b1) fe_cnt++;
      if (data_valid === 1'b1 || frame_err === 1'b1) begin
         n_checks++;
         if (data_valid === 1'b1 && frame_err === 1'b1) begin
            n_fail++;
            $display("FAIL strobe_exclusive: data_valid=%b frame_err=%b, expected not both high", data_valid, frame_err);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected line for one frame: start bit 1, data MSB-first, 0 = high/low, 1 = low/high, idle low.
   function automatic wave_t tx_model(input logic [7:0] b, input int half);
      wave_t w;
      logic [8:0] f;
      f = {1'b1, b};
      for (int k = 8; k >= 0; k--) begin
         for (int i = 0; i < half; i++) w.push_back(~f[k]);
         for (int i = 0; i < half; i++) w.push_back(f[k]);
      end
      for (int i = 0; i < IDLE * 2 * half; i++) w.push_back(1'b0);
      return w;
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
      if (slow_se) sample_en = ~sample_en;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w;
      w = 0;
      while (s_axis_tready !== 1'b1 && w < 300) begin
         tick();
         w++;
      end
      n_checks++;
      if (s_axis_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready: s_axis_tready=%b after %0d cycles, expected 1", s_axis_tready, w);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b;
      tick();
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'($urandom);
   endtask

   task automatic wait_rx(input int n);
      int w;
      w = 0;
      while (rx_q.size() < n && w < 150 * n + 200) begin
         tick();
         w++;
      end
      repeat (60) tick();
   endtask

   task automatic drive_frame(input logic [7:0] b, input int half, input int miss_k);
      wave_t w;
      w = tx_model(b, half);
      if (miss_k >= 0)
         for (int i = 0; i < half; i++) w[miss_k * 2 * half + half + i] = w[miss_k * 2 * half];
      ext_line = 1'b0;
      for (int i = 0; i < 4 * half; i++) tick();
      for (int i = 0; i < w.size(); i++) begin
         ext_line = w[i];
         tick();
      end
      ext_line = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (serial_out !== 1'b0) begin n_fail++; $display("FAIL reset_serial_out: got %b expected 0", serial_out); end
      n_checks++;
      if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b expected 0", s_axis_tready); end
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      areset = 1'b0;
      tick();
      n_checks++;
      if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL reset_release_tready: got %b expected 1", s_axis_tready); end
   endtask

   task automatic test_waveform(input logic [7:0] b);
      wave_t w;
      int bad, low;
      w = tx_model(b, H);
      loop_en = 1'b1;
      send_byte(b);
      bad = 0;
      low = 0;
      while (s_axis_tready === 1'b0 && low < 200) begin
         if (low < FRAME_LEN && serial_out !== w[low]) bad++;
         low++;
         tick();
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL waveform_%h: %0d cycles differ from expected line, expected 0", b, bad); end
      n_checks++;
      if (low != FRAME_LEN) begin n_fail++; $display("FAIL tready_low_%h: low for %0d cycles, expected %0d", b, low, FRAME_LEN); end
   endtask

   task automatic loopback_round(input int n, input bit fixed);
      logic [7:0] fixed_tab[3];
      logic [7:0] exp_q[$];
      int f0;
      fixed_tab = '{8'hF0, 8'h0F, 8'hAA};
      loop_en = 1'b1;
      rx_q.delete();
      f0 = fe_cnt;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(fixed ? fixed_tab[i % 3] : 8'($urandom));
         send_byte(exp_q[i]);
      end
      wait_rx(n);
      n_checks++;
      if (rx_q.size() != n) begin n_fail++; $display("FAIL loopback_count: got %0d bytes expected %0d", rx_q.size(), n); end
      for (int i = 0; i < n; i++) begin
         if (i < rx_q.size()) begin
            n_checks++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL loopback_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
         end
      end
      n_checks++;
      if (fe_cnt != f0) begin n_fail++; $display("FAIL loopback_frame_err: got %0d errors expected 0", fe_cnt - f0); end
   endtask

   task automatic test_loopback();
      loopback_round(3, 1'b1);
      loopback_round(4, 1'b0);
   endtask

   task automatic test_back_to_back();
      int c, hs1, hs2;
      loop_en = 1'b1;
      rx_q.delete();
      c = 0; hs1 = -1; hs2 = -1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h55;
      while (hs2 < 0 && c < 400) begin
         if (s_axis_tready === 1'b1) begin
            if (hs1 < 0) hs1 = c;
            else         hs2 = c;
         end
         tick();
         c++;
         s_axis_tdata = (hs1 < 0) ? 8'h55 : ((s_axis_tready === 1'b1) ? 8'h33 : 8'($urandom));
      end
      s_axis_tvalid = 1'b0;
      n_checks++;
      if (hs2 - hs1 != FRAME_LEN + 1) begin n_fail++; $display("FAIL b2b_spacing: handshakes %0d cycles apart, expected %0d", hs2 - hs1, FRAME_LEN + 1); end
      n_checks++;
      if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL b2b_tready_drop: got %b expected 0", s_axis_tready); end
      wait_rx(2);
      n_checks++;
      if (rx_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d bytes expected 2", rx_q.size()); end
      if (rx_q.size() >= 2) begin
         n_checks++;
         if (rx_q[0] !== 8'h55) begin n_fail++; $display("FAIL b2b_first: got %h expected 55", rx_q[0]); end
         n_checks++;
         if (rx_q[1] !== 8'h33) begin n_fail++; $display("FAIL b2b_second: got %h expected 33", rx_q[1]); end
      end
   endtask

   task automatic test_frame_err();
      int f0;
      loop_en = 1'b0;
      rx_q.delete();
      f0 = fe_cnt;
      drive_frame(8'hF0, H, 4);
      repeat (20) tick();
      n_checks++;
      if (fe_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - f0); end
      n_checks++;
      if (rx_q.size() != 0) begin n_fail++; $display("FAIL ferr_no_data: got %0d bytes expected 0", rx_q.size()); end
      drive_frame(8'h3C, H, -1);
      repeat (20) tick();
      n_checks++;
      if (rx_q.size() != 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d bytes expected 1", rx_q.size()); end
      if (rx_q.size() >= 1) begin
         n_checks++;
         if (rx_q[0] !== 8'h3C) begin n_fail++; $display("FAIL ferr_recover_byte: got %h expected 3c", rx_q[0]); end
      end
      n_checks++;
      if (fe_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_recover_errs: got %0d expected 1", fe_cnt - f0); end
      loop_en = 1'b1;
   endtask

   task automatic test_reset_midframe();
      int f0;
      loop_en = 1'b1;
      rx_q.delete();
      f0 = fe_cnt;
      send_byte(8'($urandom));
      repeat (30) tick();
      areset = 1'b1;
      tick();
      n_checks++;
      if (serial_out !== 1'b0) begin n_fail++; $display("FAIL midrst_serial_out: got %b expected 0", serial_out); end
      n_checks++;
      if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_tready: got %b expected 0", s_axis_tready); end
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data_out: got %h expected 00", data_out); end
      n_checks++;
      if (data_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_strobes: dv=%b fe=%b expected 0 0", data_valid, frame_err); end
      areset = 1'b0;
      repeat (120) tick();
      n_checks++;
      if (rx_q.size() != 0 || fe_cnt != f0) begin n_fail++; $display("FAIL midrst_quiet: %0d bytes %0d errors, expected 0 0", rx_q.size(), fe_cnt - f0); end
      send_byte(8'h81);
      wait_rx(1);
      n_checks++;
      if (rx_q.size() != 1) begin n_fail++; $display("FAIL midrst_next_count: got %0d bytes expected 1", rx_q.size()); end
      if (rx_q.size() >= 1) begin
         n_checks++;
         if (rx_q[0] !== 8'h81) begin n_fail++; $display("FAIL midrst_next_byte: got %h expected 81", rx_q[0]); end
      end
   endtask

   task automatic test_slow_sample();
      logic [7:0] exp_q[$];
      int f0;
      loop_en = 1'b0;
      rx_q.delete();
      f0 = fe_cnt;
      slow_se = 1'b1;
      exp_q.push_back(8'hC5);
      exp_q.push_back(8'($urandom));
      exp_q.push_back(8'($urandom));
      foreach (exp_q[i]) drive_frame(exp_q[i], 2 * H, -1);
      slow_se = 1'b0;
      sample_en = 1'b1;
      repeat (10) tick();
      n_checks++;
      if (rx_q.size() != 3) begin n_fail++; $display("FAIL slow_count: got %0d bytes expected 3", rx_q.size()); end
      for (int i = 0; i < 3; i++) begin
         if (i < rx_q.size()) begin
            n_checks++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL slow_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
         end
      end
      n_checks++;
      if (fe_cnt != f0) begin n_fail++; $display("FAIL slow_frame_err: got %0d errors expected 0", fe_cnt - f0); end
      loop_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_waveform(8'hAA);
      test_waveform(8'($urandom));
      test_waveform(8'($urandom));
      test_loopback();
      test_back_to_back();
      test_frame_err();
      test_reset_midframe();
      test_slow_sample();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/manchester_codec.md
Name: manchester_codec

Overview:
- Byte-oriented Manchester line codec with a transmitter and a receiver.
- TX accepts 8-bit words on an AXI-Stream-style slave handshake and emits a framed, MSB-first Manchester serial stream.
- RX oversamples a serial line, recovers the framed bytes and presents each on a one-cycle valid strobe.
- Used as a serial-link endpoint; serial_out is looped to serial_in for self-test.

Parameters:
- HALF_BIT_CYCLES, 4, clocks (TX) or sample_en ticks (RX) per Manchester half-bit (H); must be even and >= 4.
- IDLE_BITS, 2, minimum bit periods of low idle line after each frame.

Ports:
- aclk  in  1  system clock, all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  input byte valid.
- s_axis_tready  out  1  TX can accept a byte.
- s_axis_tdata  in  8  byte to transmit.
- serial_out  out  1  Manchester line output.
- serial_in  in  1  Manchester line input (asynchronous).
- sample_en  in  1  RX clock enable; RX timers advance only on cycles where it is high.
- data_out  out  8  last decoded byte, held until the next byte is decoded.
- data_valid  out  1  one-cycle strobe: data_out has been updated.
- frame_err  out  1  one-cycle strobe: frame aborted.

Behaviour:
- Line code (IEEE 802.3): bit 1 is low then high; bit 0 is high then low. Each half lasts H.
- Idle line is low.
- Frame: start bit 1, then data bits 7..0, then IDLE_BITS*2H cycles of low.
- TX frame length is (9 + IDLE_BITS)*2H cycles, which is 88 at the defaults.
- Reset values: serial_out 0, s_axis_tready 0, data_out 0x00, data_valid 0, frame_err 0. Both FSMs go to IDLE.
- s_axis_tready goes to 1 on the first cycle after areset is released.
- TX FSM states: IDLE, SEND (18 half-bits), GAP.
  - In IDLE, s_axis_tready=1.
  - A transfer happens when s_axis_tvalid && s_axis_tready. The byte is latched, tready drops the next cycle, and the first start-bit half is driven the cycle after acceptance.
  - tready stays 0 through SEND and GAP, then returns to 1 in IDLE.
  - tvalid held high back-to-back gives one byte per frame.
  - tdata is ignored while tready=0.
- RX input path: serial_in passes through a 2-flop synchronizer on aclk, independent of sample_en. Edges are detected on the synchronized signal.
- RX FSM states: IDLE, BIT, WAIT_IDLE.
  - IDLE: a rising edge marks the start-bit mid-transition. Clear the timer and bit count, then go to BIT.
  - BIT: at 3H/2 ticks after the previous mid-edge, sample the level. Low gives bit 1, high gives bit 0. Shift it in MSB-first.
  - BIT: then expect an edge within ticks (3H/2, 5H/2]. The edge must be rising for a 1 and falling for a 0. On the edge, restart the timer (resynchronisation).
  - BIT: a missing edge or wrong direction pulses frame_err for one cycle, discards the byte and goes to WAIT_IDLE.
  - BIT: on the 8th valid mid-edge, load data_out and pulse data_valid on the next cycle, then go to WAIT_IDLE.
  - WAIT_IDLE: return to IDLE after 2H consecutive low samples. Edges are ignored in this state, including the trailing falling edge after a final 1.
- areset mid-frame: TX aborts and drives low. RX discards its partial byte and produces no data_valid and no frame_err.
- data_valid and frame_err are never high in the same cycle.

Decomposition:
- Package manchester_pkg holds:
  - the RX/TX state enums;
  - the constants FRAME_BITS=9 and DATA_BITS=8;
  - derived timer widths via $clog2 of the (9+IDLE_BITS)*2H frame length.
- One sub-module, manchester_rx: synchronizer, edge detect, RX FSM and shift register.
- TX stays inline in manchester_codec.

Test Plan:
- Loopback (serial_out to serial_in, sample_en=1); send 0xF0, 0x0F, 0xAA -> data_valid pulses exactly three times with data_out 0xF0, 0x0F, 0xAA in order.
- Send 0xAA with H=4 -> serial_out shows:
  - start: 4 low, 4 high;
  - then alternating 1/0 symbols;
  - then 16 cycles low;
  - tready low for exactly 88 cycles.
- Hold tvalid high with 0x55 then 0x33 -> one handshake per frame; second byte starts the cycle after tready re-asserts.
- Drive serial_in externally with a missing mid-bit transition at bit 4 -> frame_err one pulse; no data_valid. Next good frame 0x3C decodes correctly.
- Assert areset for 1 cycle mid-frame -> serial_out 0 and outputs at reset values; next byte 0x81 decodes correctly.
- Drive serial_in at 8 clocks per half-bit with sample_en high every other cycle -> 0xC5 decodes correctly.
